// File: rtl/timer_sequencer_if.sv
// rtl/timer_sequencer_if.sv - control bundle between the phase sequencer and the BCD seconds timer
interface timer_sequencer_if;
  logic       Tmr_Reset;
  logic       Tmr_Load;
  logic       Tmr_Start;
  logic [7:0] Tmr_Value;
  logic       Time_Out;

  modport master (output Tmr_Reset, output Tmr_Load, output Tmr_Start, output Tmr_Value, input Time_Out);
  modport slave  (input Tmr_Reset, input Tmr_Load, input Tmr_Start, input Tmr_Value, output Time_Out);
endinterface

// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - steps a BCD seconds timer through a programmed list of phase presets
// Optional TIMER_SEQ_LOOP_EN adds a Loop input that restarts the sequence without visiting IDLE.
module timer_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Prog_We,
  input  logic [PTR_W-1:0] Prog_Addr,
  input  logic [7:0]       Prog_Data,
  input  logic [PTR_W:0]   Num_Phases,
  input  logic             Go,
  input  logic             Abort,
`ifdef TIMER_SEQ_LOOP_EN
  input  logic             Loop,
`endif
  timer_sequencer_if.master tmr,
  output logic             Busy,
  output logic [PTR_W-1:0] Phase,
  output logic             Phase_Done,
  output logic             Seq_Done,
  output logic             Prog_Err
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_START, S_RUN, S_ABORT} state_t;

  localparam logic [PTR_W:0]   DEPTH_V = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   NUM_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PH_ONE  = PTR_W'(1);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] phase_nxt;
  logic [PTR_W:0]   num_q, num_nxt;
  logic [7:0]       preset [DEPTH];
  logic             phase_done_nxt, seq_done_nxt, prog_err_nxt, wr_en;
  logic             data_ok, go_ok, last, loop_on;

  assign data_ok = (Prog_Data[7:4] <= 4'd9) && (Prog_Data[3:0] <= 4'd9) && ({1'b0, Prog_Addr} < DEPTH_V);
  assign go_ok   = (Num_Phases != '0) && (Num_Phases <= DEPTH_V);
  assign last    = ({1'b0, Phase} == (num_q - NUM_ONE));
`ifdef TIMER_SEQ_LOOP_EN
  assign loop_on = Loop;
`else
  assign loop_on = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    phase_nxt      = Phase;
    num_nxt        = num_q;
    phase_done_nxt = 1'b0;
    seq_done_nxt   = 1'b0;
    prog_err_nxt   = 1'b0;
    wr_en          = 1'b0;
    if (state == S_IDLE) begin
      if (Prog_We) begin
        if (data_ok) wr_en = 1'b1;
        else         prog_err_nxt = 1'b1;
      end
      // Abort outranks Go; in IDLE that simply means Go is dropped.
      if (Go && !Abort) begin
        if (go_ok) begin
          state_nxt = S_CLEAR;
          num_nxt   = Num_Phases;
          phase_nxt = '0;
        end else begin
          prog_err_nxt = 1'b1;
        end
      end
    end else begin
      if (Prog_We) prog_err_nxt = 1'b1;
      if (Abort) begin
        state_nxt = (state == S_ABORT) ? S_IDLE : S_ABORT;
        phase_nxt = '0;
      end else begin
        case (state)
          S_CLEAR: state_nxt = S_LOAD;
          S_LOAD:  state_nxt = S_START;
          S_START: state_nxt = S_RUN;
          S_RUN: begin
            if (tmr.Time_Out) begin
              phase_done_nxt = 1'b1;
              if (last) begin
                seq_done_nxt = 1'b1;
                phase_nxt    = '0;
                state_nxt    = loop_on ? S_CLEAR : S_IDLE;
              end else begin
                phase_nxt = Phase + PH_ONE;
                state_nxt = S_CLEAR;
              end
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= S_IDLE;
      Phase         <= '0;
      num_q         <= '0;
      Busy          <= 1'b0;
      Phase_Done    <= 1'b0;
      Seq_Done      <= 1'b0;
      Prog_Err      <= 1'b0;
      tmr.Tmr_Reset <= 1'b0;
      tmr.Tmr_Load  <= 1'b0;
      tmr.Tmr_Start <= 1'b0;
      tmr.Tmr_Value <= 8'h00;
      for (int i = 0; i < DEPTH; i++) preset[i] <= 8'h00;
    end else begin
      state         <= state_nxt;
      Phase         <= phase_nxt;
      num_q         <= num_nxt;
      Busy          <= (state_nxt != S_IDLE);
      Phase_Done    <= phase_done_nxt;
      Seq_Done      <= seq_done_nxt;
      Prog_Err      <= prog_err_nxt;
      tmr.Tmr_Reset <= (state_nxt == S_CLEAR) || (state_nxt == S_ABORT);
      tmr.Tmr_Load  <= (state_nxt == S_LOAD);
      tmr.Tmr_Start <= (state_nxt == S_START);
      if (state_nxt == S_LOAD) tmr.Tmr_Value <= preset[phase_nxt];
      if (wr_en) preset[Prog_Addr] <= Prog_Data;
    end
  end

endmodule
